// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared constants for the ATM account arbiter
package atm_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic TIPO_RETIRO   = 1'b1;
    localparam logic TIPO_DEPOSITO = 1'b0;

    localparam logic [63:0] BALANCE_INIT_DEFAULT = 64'h0AF0_0000;

endpackage

// File: rtl/atm_account_arbiter_if.sv
// rtl/atm_account_arbiter_if.sv - requester/arbiter handshake bundle
interface atm_account_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int BAL_W   = 64,
    parameter int MONTO_W = 32
) ();

    logic [N_REQ-1:0]         REQ;
    logic [N_REQ-1:0]         REQ_TIPO;
    logic [N_REQ*MONTO_W-1:0] REQ_MONTO;
    logic [N_REQ-1:0]         GNT;
    logic [N_REQ-1:0]         DONE;
    logic                     ENTREGAR_DINERO;
    logic                     FONDOS_INSUFICIENTES;
    logic                     BALANCE_ACTUALIZADO;
    logic                     DESBORDE;
    logic [BAL_W-1:0]         BALANCE;

    modport master (
        output REQ, REQ_TIPO, REQ_MONTO,
        input  GNT, DONE, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
        input  BALANCE_ACTUALIZADO, DESBORDE, BALANCE
    );

    modport slave (
        input  REQ, REQ_TIPO, REQ_MONTO,
        output GNT, DONE, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
        output BALANCE_ACTUALIZADO, DESBORDE, BALANCE
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    int               pos;
    logic [IDX_W-1:0] pos_idx;

    always_comb begin
        found   = 1'b0;
        gnt     = '0;
        idx     = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (!found && req[pos_idx]) begin
                found        = 1'b1;
                gnt[pos_idx] = 1'b1;
                idx          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/atm_account_arbiter.sv
// rtl/atm_account_arbiter.sv - round-robin shared balance with atomic deposit/withdrawal
module atm_account_arbiter
    import atm_pkg::*;
#(
    parameter int               N_REQ        = 4,
    parameter int               BAL_W        = 64,
    parameter int               MONTO_W      = 32,
    parameter logic [BAL_W-1:0] BALANCE_INIT = BAL_W'(BALANCE_INIT_DEFAULT)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    atm_account_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [1:0]         state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   idx_q;
    logic               tipo_q;
    logic [MONTO_W-1:0] monto_q;
    logic [BAL_W-1:0]   balance_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   done_q;
    logic               entregar_q;
    logic               fondos_q;
    logic               actualizado_q;
    logic               desborde_q;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;

    logic [BAL_W-1:0]   monto_ext;
    logic [BAL_W:0]     sum;
    logic [BAL_W-1:0]   diff;
    logic               no_funds;
    logic               carry;
    logic               monto_nz;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (bus.REQ),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Both outcomes are computed up front; the carry bit guards deposits so the balance never wraps.
    assign monto_ext = BAL_W'(monto_q);
    assign sum       = {1'b0, balance_q} + {1'b0, monto_ext};
    assign diff      = balance_q - monto_ext;
    assign no_funds  = (monto_ext > balance_q);
    assign carry     = sum[BAL_W];
    assign monto_nz  = |monto_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            idx_q         <= '0;
            tipo_q        <= 1'b0;
            monto_q       <= '0;
            balance_q     <= BALANCE_INIT;
            gnt_q         <= '0;
            done_q        <= '0;
            entregar_q    <= 1'b0;
            fondos_q      <= 1'b0;
            actualizado_q <= 1'b0;
            desborde_q    <= 1'b0;
        end else begin
            gnt_q         <= '0;
            done_q        <= '0;
            entregar_q    <= 1'b0;
            fondos_q      <= 1'b0;
            actualizado_q <= 1'b0;
            desborde_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|bus.REQ) begin
                        idx_q   <= arb_idx;
                        tipo_q  <= bus.REQ_TIPO[arb_idx];
                        monto_q <= bus.REQ_MONTO[arb_idx*MONTO_W +: MONTO_W];
                        gnt_q   <= arb_gnt;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A requester that lets go mid-transaction forfeits it without moving the pointer.
                    if (!bus.REQ[idx_q]) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                        done_q  <= N_REQ'(1) << idx_q;
                        if (tipo_q == TIPO_RETIRO) begin
                            if (no_funds) begin
                                fondos_q <= 1'b1;
                            end else begin
                                balance_q     <= diff;
                                entregar_q    <= 1'b1;
                                actualizado_q <= monto_nz;
                            end
                        end else begin
                            if (carry) begin
                                desborde_q <= 1'b1;
                            end else begin
                                balance_q     <= sum[BAL_W-1:0];
                                actualizado_q <= monto_nz;
                            end
                        end
                    end
                end
                S_RESP: begin
                    rr_ptr_q <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.GNT                  = gnt_q;
    assign bus.DONE                 = done_q;
    assign bus.ENTREGAR_DINERO      = entregar_q;
    assign bus.FONDOS_INSUFICIENTES = fondos_q;
    assign bus.BALANCE_ACTUALIZADO  = actualizado_q;
    assign bus.DESBORDE             = desborde_q;
    assign bus.BALANCE              = balance_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb/tb_atm_account_arbiter.sv - directed self-checking bench for atm_account_arbiter
module tb_atm_account_arbiter;
    import atm_pkg::*;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    atm_account_arbiter_if #(.N_REQ(4), .BAL_W(64), .MONTO_W(32)) bus  ();
    atm_account_arbiter_if #(.N_REQ(4), .BAL_W(64), .MONTO_W(32)) bus2 ();

    atm_account_arbiter #(.N_REQ(4), .BAL_W(64), .MONTO_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    atm_account_arbiter #(
        .N_REQ(4), .BAL_W(64), .MONTO_W(32),
        .BALANCE_INIT(64'hFFFF_FFFF_FFFF_FE00)
    ) dut2 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus2)
    );

    function automatic logic [3:0] st1();
        return {bus.ENTREGAR_DINERO, bus.FONDOS_INSUFICIENTES, bus.BALANCE_ACTUALIZADO, bus.DESBORDE};
    endfunction

    function automatic logic [3:0] st2();
        return {bus2.ENTREGAR_DINERO, bus2.FONDOS_INSUFICIENTES, bus2.BALANCE_ACTUALIZADO, bus2.DESBORDE};
    endfunction

    task automatic idle_inputs();
        bus.REQ        = '0;
        bus.REQ_TIPO   = '0;
        bus.REQ_MONTO  = '0;
        bus2.REQ       = '0;
        bus2.REQ_TIPO  = '0;
        bus2.REQ_MONTO = '0;
    endtask

    // Drives one request, waits a bounded time for DONE, releases, and returns in IDLE.
    task automatic run_txn(input bit sel, input int i, input logic tipo, input logic [31:0] monto,
                           output logic [3:0] done_o, output logic [3:0] st_o, output int lat);
        logic [3:0] d;
        done_o = '0;
        st_o   = '0;
        lat    = -1;
        if (!sel) begin
            bus.REQ[i] = 1'b1; bus.REQ_TIPO[i] = tipo; bus.REQ_MONTO[i*32 +: 32] = monto;
        end else begin
            bus2.REQ[i] = 1'b1; bus2.REQ_TIPO[i] = tipo; bus2.REQ_MONTO[i*32 +: 32] = monto;
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            d = sel ? bus2.DONE : bus.DONE;
            if (d != 4'b0) begin
                done_o = d;
                st_o   = sel ? st2() : st1();
                lat    = c;
                break;
            end
        end
        if (!sel) bus.REQ[i] = 1'b0;
        else      bus2.REQ[i] = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.BALANCE !== 64'h0AF0_0000) begin
            errors++; $display("FAIL reset_balance: got %h expected %h", bus.BALANCE, 64'h0AF0_0000);
        end
        checks++;
        if (bus.GNT !== 4'b0 || bus.DONE !== 4'b0 || st1() !== 4'b0) begin
            errors++; $display("FAIL reset_outputs: got gnt=%b done=%b st=%b expected all 0", bus.GNT, bus.DONE, st1());
        end
        checks++;
        if (bus2.BALANCE !== 64'hFFFF_FFFF_FFFF_FE00) begin
            errors++; $display("FAIL reset_balance2: got %h expected %h", bus2.BALANCE, 64'hFFFF_FFFF_FFFF_FE00);
        end
        bus.REQ[0] = 1'b1; bus.REQ_TIPO[0] = TIPO_RETIRO; bus.REQ_MONTO[31:0] = 32'h100;
        @(negedge CLK);
        checks++;
        if (bus.GNT !== 4'b0001) begin
            errors++; $display("FAIL reset_pre_gnt: got %b expected 0001", bus.GNT);
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.DONE !== 4'b0 || bus.GNT !== 4'b0 || bus.BALANCE !== 64'h0AF0_0000) begin
            errors++; $display("FAIL reset_mid_exec: got done=%b gnt=%b bal=%h expected 0/0/%h",
                               bus.DONE, bus.GNT, bus.BALANCE, 64'h0AF0_0000);
        end
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.DONE !== 4'b0 || bus.BALANCE !== 64'h0AF0_0000) begin
            errors++; $display("FAIL reset_after: got done=%b bal=%h expected 0/%h", bus.DONE, bus.BALANCE, 64'h0AF0_0000);
        end
    endtask

    task automatic test_single_withdrawal();
        bus.REQ[0] = 1'b1; bus.REQ_TIPO[0] = TIPO_RETIRO; bus.REQ_MONTO[31:0] = 32'h100;
        @(negedge CLK);
        checks++;
        if (bus.GNT !== 4'b0001 || bus.DONE !== 4'b0) begin
            errors++; $display("FAIL wd_gnt_t1: got gnt=%b done=%b expected 0001/0000", bus.GNT, bus.DONE);
        end
        @(negedge CLK);
        checks++;
        if (bus.DONE !== 4'b0001 || st1() !== 4'b1010 || bus.GNT !== 4'b0) begin
            errors++; $display("FAIL wd_done_t2: got done=%b st=%b gnt=%b expected 0001/1010/0000", bus.DONE, st1(), bus.GNT);
        end
        checks++;
        if (bus.BALANCE !== 64'h0AEF_FF00) begin
            errors++; $display("FAIL wd_balance: got %h expected %h", bus.BALANCE, 64'h0AEF_FF00);
        end
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (bus.DONE !== 4'b0 || st1() !== 4'b0) begin
            errors++; $display("FAIL wd_pulse_width: got done=%b st=%b expected 0", bus.DONE, st1());
        end
    endtask

    task automatic test_insufficient();
        logic [3:0] d, s;
        int         lat;
        run_txn(1'b0, 0, TIPO_RETIRO, 32'h0AF0_0001, d, s, lat);
        checks++;
        if (d !== 4'b0001 || s !== 4'b0100 || lat != 2) begin
            errors++; $display("FAIL insuf_status: got done=%b st=%b lat=%0d expected 0001/0100/2", d, s, lat);
        end
        checks++;
        if (bus.BALANCE !== 64'h0AEF_FF00) begin
            errors++; $display("FAIL insuf_balance: got %h expected %h", bus.BALANCE, 64'h0AEF_FF00);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] order;
        int         n;
        int         bad_st;
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        bus.REQ = 4'b1111;
        bus.REQ_TIPO = {4{TIPO_DEPOSITO}};
        bus.REQ_MONTO = {32'd4, 32'd3, 32'd2, 32'd1};
        order = '0; n = 0; bad_st = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge CLK);
            if (bus.DONE != 4'b0) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.DONE[b]) begin
                        order = {order[5:0], 2'(b)};
                        bus.REQ[b] = 1'b0;
                    end
                end
                if (st1() !== 4'b0010 || $countones(bus.DONE) != 1) bad_st++;
                n++;
            end
        end
        @(negedge CLK);
        checks++;
        if (n != 4 || order !== 8'b00_01_10_11) begin
            errors++; $display("FAIL rr_order: got n=%0d order=%b expected 4/00011011", n, order);
        end
        checks++;
        if (bad_st != 0) begin
            errors++; $display("FAIL rr_status: got %0d bad pulses expected 0", bad_st);
        end
        checks++;
        if (bus.BALANCE !== 64'h0AF0_000A) begin
            errors++; $display("FAIL rr_balance: got %h expected %h", bus.BALANCE, 64'h0AF0_000A);
        end
        bus.REQ = 4'b1001;
        bus.REQ_MONTO = '0;
        order = '0; n = 0; bad_st = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge CLK);
            if (bus.DONE != 4'b0) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.DONE[b]) begin
                        order = {order[5:0], 2'(b)};
                        bus.REQ[b] = 1'b0;
                    end
                end
                if (st1() !== 4'b0000) bad_st++;
                n++;
            end
        end
        @(negedge CLK);
        checks++;
        if (n != 2 || order[3:0] !== 4'b00_11 || bad_st != 0) begin
            errors++; $display("FAIL rr_reorder: got n=%0d order=%b bad=%0d expected 2/0011/0", n, order[3:0], bad_st);
        end
        checks++;
        if (bus.BALANCE !== 64'h0AF0_000A) begin
            errors++; $display("FAIL rr_zero_dep_balance: got %h expected %h", bus.BALANCE, 64'h0AF0_000A);
        end
    endtask

    task automatic test_boundaries();
        logic [3:0] d, s;
        int         lat;
        run_txn(1'b0, 1, TIPO_RETIRO, 32'h0, d, s, lat);
        checks++;
        if (d !== 4'b0010 || s !== 4'b1000 || bus.BALANCE !== 64'h0AF0_000A) begin
            errors++; $display("FAIL zero_withdraw: got done=%b st=%b bal=%h expected 0010/1000/%h", d, s, bus.BALANCE, 64'h0AF0_000A);
        end
        run_txn(1'b0, 2, TIPO_RETIRO, 32'h0AF0_000A, d, s, lat);
        checks++;
        if (d !== 4'b0100 || s !== 4'b1010 || bus.BALANCE !== 64'h0) begin
            errors++; $display("FAIL exact_withdraw: got done=%b st=%b bal=%h expected 0100/1010/0", d, s, bus.BALANCE);
        end
    endtask

    task automatic test_abort();
        bus.REQ[2] = 1'b1; bus.REQ_TIPO[2] = TIPO_DEPOSITO; bus.REQ_MONTO[95:64] = 32'd5;
        @(negedge CLK);
        checks++;
        if (bus.GNT !== 4'b0100) begin
            errors++; $display("FAIL abort_gnt2: got %b expected 0100", bus.GNT);
        end
        bus.REQ[2] = 1'b0;
        bus.REQ[1] = 1'b1; bus.REQ_TIPO[1] = TIPO_DEPOSITO; bus.REQ_MONTO[63:32] = 32'd7;
        @(negedge CLK);
        checks++;
        if (bus.DONE !== 4'b0 || bus.GNT !== 4'b0 || bus.BALANCE !== 64'h0 || st1() !== 4'b0) begin
            errors++; $display("FAIL abort_nodone: got done=%b gnt=%b bal=%h st=%b expected 0/0/0/0", bus.DONE, bus.GNT, bus.BALANCE, st1());
        end
        @(negedge CLK);
        checks++;
        if (bus.GNT !== 4'b0010) begin
            errors++; $display("FAIL abort_next_gnt: got %b expected 0010", bus.GNT);
        end
        @(negedge CLK);
        checks++;
        if (bus.DONE !== 4'b0010 || st1() !== 4'b0010 || bus.BALANCE !== 64'd7) begin
            errors++; $display("FAIL abort_next_done: got done=%b st=%b bal=%h expected 0010/0010/7", bus.DONE, st1(), bus.BALANCE);
        end
        idle_inputs();
        @(negedge CLK);
    endtask

    task automatic test_overflow();
        logic [3:0] d, s;
        int         lat;
        run_txn(1'b1, 0, TIPO_DEPOSITO, 32'h100, d, s, lat);
        checks++;
        if (d !== 4'b0001 || s !== 4'b0010 || bus2.BALANCE !== 64'hFFFF_FFFF_FFFF_FF00) begin
            errors++; $display("FAIL ovf_preload: got done=%b st=%b bal=%h expected 0001/0010/FFFFFFFFFFFFFF00", d, s, bus2.BALANCE);
        end
        run_txn(1'b1, 1, TIPO_DEPOSITO, 32'h100, d, s, lat);
        checks++;
        if (d !== 4'b0010 || s !== 4'b0001 || bus2.BALANCE !== 64'hFFFF_FFFF_FFFF_FF00) begin
            errors++; $display("FAIL ovf_reject: got done=%b st=%b bal=%h expected 0010/0001/FFFFFFFFFFFFFF00", d, s, bus2.BALANCE);
        end
        run_txn(1'b1, 2, TIPO_DEPOSITO, 32'hFF, d, s, lat);
        checks++;
        if (d !== 4'b0100 || s !== 4'b0010 || bus2.BALANCE !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL ovf_fill: got done=%b st=%b bal=%h expected 0100/0010/FFFFFFFFFFFFFFFF", d, s, bus2.BALANCE);
        end
        run_txn(1'b1, 3, TIPO_DEPOSITO, 32'h1, d, s, lat);
        checks++;
        if (d !== 4'b1000 || s !== 4'b0001 || bus2.BALANCE !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL ovf_by_one: got done=%b st=%b bal=%h expected 1000/0001/FFFFFFFFFFFFFFFF", d, s, bus2.BALANCE);
        end
        checks++;
        if (bus.BALANCE !== 64'd7) begin
            errors++; $display("FAIL ovf_isolation: got %h expected 7", bus.BALANCE);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_withdrawal();
        test_insufficient();
        test_round_robin();
        test_boundaries();
        test_abort();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
